// File: rtl/icache_assoc_burst_if.sv
// rtl/icache_assoc_burst_if.sv - IFU fetch, flush and memory burst signal bundle for icache_assoc_burst
interface icache_assoc_burst_if #(
    parameter int ADDR_W = 32
);
    // IFU fetch channel
    logic              ifu_arvalid;
    logic              ifu_arready;
    logic [ADDR_W-3:0] ifu_raddr;
    logic              ifu_rvalid;
    logic              ifu_rready;
    logic [31:0]       ifu_rdata;
    logic [2:0]        ifu_rresp;
    // whole-cache invalidate
    logic              flush_valid;
    logic              flush_ready;
    // memory burst channel
    logic              mem_arvalid;
    logic              mem_arready;
    logic [ADDR_W-1:0] mem_araddr;
    logic [7:0]        mem_arlen;
    logic              mem_rvalid;
    logic              mem_rready;
    logic [31:0]       mem_rdata;
    logic [2:0]        mem_rresp;
    logic              mem_rlast;

    // environment side: IFU and memory bus models
    modport master (
        output ifu_arvalid, ifu_raddr, ifu_rready, flush_valid,
               mem_arready, mem_rvalid, mem_rdata, mem_rresp, mem_rlast,
        input  ifu_arready, ifu_rvalid, ifu_rdata, ifu_rresp, flush_ready,
               mem_arvalid, mem_araddr, mem_arlen, mem_rready
    );

    // cache side
    modport slave (
        input  ifu_arvalid, ifu_raddr, ifu_rready, flush_valid,
               mem_arready, mem_rvalid, mem_rdata, mem_rresp, mem_rlast,
        output ifu_arready, ifu_rvalid, ifu_rdata, ifu_rresp, flush_ready,
               mem_arvalid, mem_araddr, mem_arlen, mem_rready
    );
endinterface

// File: rtl/icache_assoc_burst.sv
// rtl/icache_assoc_burst.sv - set-associative RV32 instruction cache with burst line refill (optional ICACHE_PERF_CNT_EN counters)
module icache_assoc_burst #(
    parameter int ADDR_W     = 32,
    parameter int WAY_NUM    = 4,
    parameter int SET_NUM    = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    icache_assoc_burst_if.slave   bus
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0]           perf_access,
    output logic [31:0]           perf_hit
`endif
);
    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(SET_NUM);
    localparam int TAG_W = ADDR_W - 2 - OFF_W - IDX_W;
    localparam int WAY_W = (WAY_NUM > 1) ? $clog2(WAY_NUM) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_REFILL_ADDR,
        S_REFILL_DATA,
        S_RESP
    } state_t;

    state_t              state_q;
    logic                arready_q;
    logic                rvalid_q;
    logic [31:0]         rdata_q;
    logic [2:0]          rresp_q;
    logic                mem_arvalid_q;
    logic [ADDR_W-1:0]   mem_araddr_q;
    logic [TAG_W-1:0]    req_tag_q;
    logic [IDX_W-1:0]    req_idx_q;
    logic [OFF_W-1:0]    req_off_q;
    logic [OFF_W-1:0]    beat_q;
    logic                err_q;
    logic [WAY_W-1:0]    rr_q;
    logic [SET_NUM-1:0]  valid_q [WAY_NUM];

    // storage without reset: contents are meaningless until the matching valid bit is set
    logic [TAG_W-1:0]    tag_mem_q  [WAY_NUM][SET_NUM];
    logic [31:0]         data_mem_q [WAY_NUM][SET_NUM][LINE_WORDS];
    logic [31:0]         lbuf_q     [LINE_WORDS];

    logic                hit;
    logic [WAY_W-1:0]    hit_way;
    logic [31:0]         hit_word;
    logic                has_invalid;
    logic [WAY_W-1:0]    victim;
    logic                beat_fire;
    logic                err_d;
    logic                refill_done;
    logic                install_en;
    logic [31:0]         line_next [LINE_WORDS];

`ifdef ICACHE_PERF_CNT_EN
    logic [31:0]         perf_access_q;
    logic [31:0]         perf_hit_q;
    assign perf_access = perf_access_q;
    assign perf_hit    = perf_hit_q;
`endif

    // a pending flush blocks new fetches even though the FSM is idle
    assign bus.ifu_arready = arready_q & ~bus.flush_valid;
    assign bus.flush_ready = (state_q == S_IDLE);
    assign bus.ifu_rvalid  = rvalid_q;
    assign bus.ifu_rdata   = rdata_q;
    assign bus.ifu_rresp   = rresp_q;
    assign bus.mem_arvalid = mem_arvalid_q;
    assign bus.mem_araddr  = mem_araddr_q;
    assign bus.mem_arlen   = 8'(LINE_WORDS - 1);
    assign bus.mem_rready  = 1'b1;

    // beats only count once the address phase is over
    assign beat_fire   = (state_q == S_REFILL_DATA) && bus.mem_rvalid;
    assign err_d       = err_q | (bus.mem_rresp != 3'b000);
    assign refill_done = beat_fire && (bus.mem_rlast || (beat_q == OFF_W'(LINE_WORDS - 1)));
    assign install_en  = refill_done && !err_d;

    // tag compare across all ways of the requested set
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAY_NUM; w++) begin
            if (valid_q[w][req_idx_q] && (tag_mem_q[w][req_idx_q] == req_tag_q)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
        hit_word = data_mem_q[hit_way][req_idx_q][req_off_q];
    end

    // victim: lowest invalid way, otherwise the round-robin pointer
    always_comb begin
        victim      = rr_q;
        has_invalid = 1'b0;
        for (int w = WAY_NUM - 1; w >= 0; w--) begin
            if (!valid_q[w][req_idx_q]) begin
                victim      = WAY_W'(w);
                has_invalid = 1'b1;
            end
        end
    end

    // line buffer with the in-flight beat merged so the final beat can be installed and bypassed
    always_comb begin
        for (int i = 0; i < LINE_WORDS; i++) begin
            line_next[i] = (beat_fire && (beat_q == OFF_W'(i))) ? bus.mem_rdata : lbuf_q[i];
        end
    end

    // line buffer capture and way install
    always_ff @(posedge clk) begin
        if (beat_fire) begin
            lbuf_q[beat_q] <= bus.mem_rdata;
        end
        if (install_en) begin
            tag_mem_q[victim][req_idx_q] <= req_tag_q;
            for (int i = 0; i < LINE_WORDS; i++) begin
                data_mem_q[victim][req_idx_q][i] <= line_next[i];
            end
        end
    end

    // control FSM with registered handshake outputs, valid bits and replacement pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            arready_q     <= 1'b1;
            rvalid_q      <= 1'b0;
            rdata_q       <= '0;
            rresp_q       <= '0;
            mem_arvalid_q <= 1'b0;
            mem_araddr_q  <= '0;
            req_tag_q     <= '0;
            req_idx_q     <= '0;
            req_off_q     <= '0;
            beat_q        <= '0;
            err_q         <= 1'b0;
            rr_q          <= '0;
            for (int w = 0; w < WAY_NUM; w++) begin
                valid_q[w] <= '0;
            end
`ifdef ICACHE_PERF_CNT_EN
            perf_access_q <= '0;
            perf_hit_q    <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.flush_valid) begin
                        for (int w = 0; w < WAY_NUM; w++) begin
                            valid_q[w] <= '0;
                        end
                    end else if (bus.ifu_arvalid && arready_q) begin
                        req_off_q <= bus.ifu_raddr[OFF_W-1:0];
                        req_idx_q <= bus.ifu_raddr[OFF_W+IDX_W-1:OFF_W];
                        req_tag_q <= bus.ifu_raddr[ADDR_W-3:OFF_W+IDX_W];
                        arready_q <= 1'b0;
                        state_q   <= S_LOOKUP;
`ifdef ICACHE_PERF_CNT_EN
                        perf_access_q <= perf_access_q + 32'd1;
`endif
                    end
                end
                S_LOOKUP: begin
                    if (hit) begin
                        rvalid_q <= 1'b1;
                        rdata_q  <= hit_word;
                        rresp_q  <= 3'b000;
                        state_q  <= S_RESP;
`ifdef ICACHE_PERF_CNT_EN
                        perf_hit_q <= perf_hit_q + 32'd1;
`endif
                    end else begin
                        mem_arvalid_q <= 1'b1;
                        mem_araddr_q  <= {req_tag_q, req_idx_q, {(OFF_W + 2){1'b0}}};
                        beat_q        <= '0;
                        err_q         <= 1'b0;
                        state_q       <= S_REFILL_ADDR;
                    end
                end
                S_REFILL_ADDR: begin
                    if (bus.mem_arready) begin
                        mem_arvalid_q <= 1'b0;
                        state_q       <= S_REFILL_DATA;
                    end
                end
                S_REFILL_DATA: begin
                    if (beat_fire) begin
                        beat_q <= beat_q + 1'b1;
                        err_q  <= err_d;
                        if (refill_done) begin
                            rvalid_q <= 1'b1;
                            state_q  <= S_RESP;
                            if (err_d) begin
                                rdata_q <= '0;
                                rresp_q <= 3'b010;
                            end else begin
                                rdata_q <= line_next[req_off_q];
                                rresp_q <= 3'b000;
                                valid_q[victim][req_idx_q] <= 1'b1;
                                if (!has_invalid) begin
                                    rr_q <= (rr_q == WAY_W'(WAY_NUM - 1)) ? '0 : rr_q + 1'b1;
                                end
                            end
                        end
                    end
                end
                S_RESP: begin
                    if (bus.ifu_rready) begin
                        rvalid_q  <= 1'b0;
                        arready_q <= 1'b1;
                        state_q   <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule
